act_reader: RTL and testbench

Reader at the far end of the quantizer's output-RAM/scale-factor interface. It captures the 16 per-lane scale factors the PPU quantizer publishes and streams the 64 stored INT4 activation vectors back out of the output RAM in address order. Each vector is presented as raw INT4 and as dequantized INT18, under a valid/ready handshake with backpressure. It feeds the next layer's operand path.

---
 rtl/act_reader.sv | 143 ++++++++++++++
 tb/tb_act_reader.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/act_reader.sv
// act_reader: captures the per-lane scale-factor bank, streams the stored INT4 vectors
// out of the output RAM in address order and presents them raw and dequantized.
module act_reader #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned ADDR_W = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_sf_valid,
    input  logic [40*LANES-1:0]   i_sf_data,
    output logic                  o_ram_re,
    output logic [ADDR_W-1:0]     o_ram_addr,
    input  logic [4*LANES-1:0]    i_ram_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [4*LANES-1:0]    o_q_data,
    output logic [18*LANES-1:0]   o_deq_data,
    output logic [ADDR_W-1:0]     o_idx,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_SF,
        READ,
        DRAIN
    } state_t;

    localparam int unsigned       ENT_W = ADDR_W + 4*LANES;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    state_t              state;
    logic                sf_loaded;
    logic [40*LANES-1:0] sf_bank;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   inflight_idx;
    logic                inflight;
    logic [ENT_W-1:0]    fifo_mem [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          fifo_count;
    logic                done;
    logic                pop;
    logic [2:0]          occ_after;
    logic [ENT_W-1:0]    head;

    // Sign-magnitude rounding keeps the result symmetric, so -131072 never appears.
    function automatic logic [17:0] dequant(input logic [3:0] q, input logic [39:0] sf);
        logic signed [43:0] p;
        logic        [43:0] mag;
        logic        [43:0] rnd;
        logic        [16:0] sat;
        p   = $signed({{40{q[3]}}, q}) * $signed({{4{sf[39]}}, sf});
        mag = p[43] ? -p : p;
        rnd = (mag + 44'd512) >> 10;
        sat = (rnd > 44'd131071) ? 17'h1FFFF : rnd[16:0];
        return p[43] ? 18'(-{1'b0, sat}) : {1'b0, sat};
    endfunction

    assign o_valid    = (fifo_count != 2'd0);
    assign pop        = o_valid & i_ready;
    assign occ_after  = 3'(fifo_count) + 3'(inflight) - 3'(pop);
    assign o_ram_re   = (state == READ) && (occ_after < 3'd2);
    assign o_ram_addr = addr;
    assign head       = o_valid ? fifo_mem[rd_ptr] : '0;
    assign o_idx      = head[ENT_W-1 -: ADDR_W];
    assign o_q_data   = head[4*LANES-1:0];
    assign o_busy     = (state != IDLE);
    assign o_done     = done;

    always_comb begin
        o_deq_data = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            o_deq_data[18*i +: 18] = dequant(o_q_data[4*i +: 4], sf_bank[40*i +: 40]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            sf_loaded  <= 1'b0;
            addr       <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            fifo_count <= '0;
            done       <= 1'b0;
        end else begin
            done     <= 1'b0;
            inflight <= o_ram_re;
            if (o_ram_re) begin
                inflight_idx <= addr;
                addr         <= addr + 1'b1;
            end

            // Returning read data lands in the FIFO the cycle it arrives.
            if (inflight) begin
                fifo_mem[wr_ptr] <= {inflight_idx, i_ram_data};
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + 2'(inflight) - 2'(pop);

            if (i_sf_valid && (state == IDLE || state == WAIT_SF)) begin
                sf_bank   <= i_sf_data;
                sf_loaded <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (i_start) begin
                        addr  <= '0;
                        state <= (sf_loaded || i_sf_valid) ? READ : WAIT_SF;
                    end
                end
                WAIT_SF: begin
                    if (i_sf_valid) begin
                        state <= READ;
                    end
                end
                READ: begin
                    if (o_ram_re && addr == LAST) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && o_idx == LAST) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        sf_loaded <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_act_reader.sv
// Scoreboard bench for act_reader: stimulus pushes expected vectors, a negedge monitor
// pops and compares on every handshake and watches FIFO occupancy and output hold.
module tb_act_reader;

    localparam int LANES  = 16;
    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic                  i_clk = 1'b0;
    logic                  i_rst = 1'b1;
    logic                  i_start = 1'b0;
    logic                  i_sf_valid = 1'b0;
    logic [40*LANES-1:0]   i_sf_data = '0;
    logic                  o_ram_re;
    logic [ADDR_W-1:0]     o_ram_addr;
    logic [4*LANES-1:0]    i_ram_data = '0;
    logic                  o_valid;
    logic                  i_ready = 1'b1;
    logic [4*LANES-1:0]    o_q_data;
    logic [18*LANES-1:0]   o_deq_data;
    logic [ADDR_W-1:0]     o_idx;
    logic                  o_busy;
    logic                  o_done;

    act_reader #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
        .i_sf_valid(i_sf_valid), .i_sf_data(i_sf_data),
        .o_ram_re(o_ram_re), .o_ram_addr(o_ram_addr), .i_ram_data(i_ram_data),
        .o_valid(o_valid), .i_ready(i_ready), .o_q_data(o_q_data),
        .o_deq_data(o_deq_data), .o_idx(o_idx), .o_busy(o_busy), .o_done(o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        int                  idx;
        logic [4*LANES-1:0]  q;
        logic [18*LANES-1:0] deq;
    } exp_t;

    exp_t               sb[$];
    logic [4*LANES-1:0] ram [DEPTH];
    int                 checks = 0;
    int                 failures = 0;
    bit                 mon_on = 1'b0;
    bit                 bp_mode = 1'b0;
    int                 bp_cyc = 0;

    always @(posedge i_clk) begin
        if (o_ram_re) i_ram_data <= ram[o_ram_addr];
    end

    task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready: held high, or a stall pattern with 10-cycle gaps every 37 cycles.
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            if (bp_mode) begin
                bp_cyc++;
                i_ready = ((bp_cyc % 37) >= 10) && ((bp_cyc % 5) != 2);
            end else begin
                i_ready = 1'b1;
            end
        end
    end

    int                  cnt_m = 0;
    int                  inflight_m = 0;
    bit                  prev_stall = 1'b0;
    logic [ADDR_W-1:0]   prev_idx;
    logic [4*LANES-1:0]  prev_q;
    logic [18*LANES-1:0] prev_deq;

    initial begin
        forever begin
            @(negedge i_clk);
            if (mon_on) begin
                int   popi;
                exp_t e;
                popi = (o_valid && i_ready) ? 1 : 0;
                if (prev_stall) begin
                    chk("hold_idx_q", 384'({o_valid, o_idx, o_q_data}), 384'({1'b1, prev_idx, prev_q}));
                    chk("hold_deq", 384'(o_deq_data), 384'(prev_deq));
                end
                chk("valid_vs_occupancy", 384'(o_valid), 384'(cnt_m != 0));
                chk("occupancy_le_2", 384'(cnt_m <= 2), 384'(1));
                if (o_ram_re) chk("room_on_read", 384'((cnt_m + inflight_m - popi) < 2), 384'(1));
                if (popi == 1) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_vector", 384'(o_idx), 384'('1));
                    end else begin
                        e = sb.pop_front();
                        chk("idx", 384'(o_idx), 384'(e.idx));
                        chk("q_data", 384'(o_q_data), 384'(e.q));
                        chk("deq_data", 384'(o_deq_data), 384'(e.deq));
                    end
                end
                if (i_rst) begin
                    cnt_m      = 0;
                    inflight_m = 0;
                    prev_stall = 1'b0;
                end else begin
                    cnt_m      = cnt_m + inflight_m - popi;
                    inflight_m = o_ram_re ? 1 : 0;
                    prev_stall = o_valid && !i_ready;
                    prev_idx   = o_idx;
                    prev_q     = o_q_data;
                    prev_deq   = o_deq_data;
                end
            end
        end
    end

    task automatic next();
        @(posedge i_clk);
        #1;
    endtask

    function automatic logic [40*LANES-1:0] sf_all(input longint v);
        logic [40*LANES-1:0] r;
        for (int i = 0; i < LANES; i++) r[40*i +: 40] = 40'(v);
        return r;
    endfunction

    task automatic load_sf(input logic [40*LANES-1:0] data);
        i_sf_valid = 1'b1;
        i_sf_data  = data;
        next();
        i_sf_valid = 1'b0;
    endtask

    // With a 1.0 scale the dequantized value is the sign-extended INT4.
    task automatic fill_pattern(input int k);
        exp_t     e;
        logic [3:0] q;
        for (int a = 0; a < DEPTH; a++) begin
            e.idx = a;
            e.q   = '0;
            e.deq = '0;
            for (int i = 0; i < LANES; i++) begin
                q = 4'((a + k*i) % 16);
                e.q[4*i +: 4]    = q;
                e.deq[18*i +: 18] = {{14{q[3]}}, q};
            end
            ram[a] = e.q;
            sb.push_back(e);
        end
    endtask

    longint sp_sf  [LANES];
    int     sp_q   [LANES];
    int     sp_deq [LANES];

    task automatic fill_special();
        exp_t e;
        sp_sf  = '{64'sd1536, 64'sd137438953472, -64'sd549755813888, 64'sd1536,
                   64'sd1536, 64'sd1536, -64'sd549755813888, 64'sd1023,
                   64'sd511, 64'sd512, 64'sd134216704, 64'sd134217216,
                   -64'sd134217728, 64'sd1024, 64'sd1024, 64'sd0};
        sp_q   = '{-3, 7, -8, 3, 1, -1, 7, 1, 1, -1, 1, 1, 1, -8, 7, 5};
        sp_deq = '{-5, 131071, 131071, 5, 2, -2, -131071, 1,
                   0, -1, 131071, 131071, -131071, -8, 7, 0};
        for (int i = 0; i < LANES; i++) i_sf_data[40*i +: 40] = 40'(sp_sf[i]);
        for (int a = 0; a < DEPTH; a++) begin
            e.idx = a;
            e.q   = '0;
            e.deq = '0;
            if (a == 0 || a == 5 || a == DEPTH-1) begin
                for (int i = 0; i < LANES; i++) begin
                    e.q[4*i +: 4]     = 4'(sp_q[i]);
                    e.deq[18*i +: 18] = 18'(sp_deq[i]);
                end
            end
            ram[a] = e.q;
            sb.push_back(e);
        end
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (cyc < limit) begin
            @(posedge i_clk);
            #2;
            cyc++;
            if (o_done) break;
        end
        chk("done_seen", 384'(o_done), 384'(1));
    endtask

    initial begin
        int cyc;
        logic [40*LANES-1:0] sp_bank;

        next();
        next();
        i_rst = 1'b0;
        #1;
        chk("rst_ram_re", 384'(o_ram_re), 384'(0));
        chk("rst_ram_addr", 384'(o_ram_addr), 384'(0));
        chk("rst_valid", 384'(o_valid), 384'(0));
        chk("rst_busy", 384'(o_busy), 384'(0));
        chk("rst_done", 384'(o_done), 384'(0));
        chk("rst_idx", 384'(o_idx), 384'(0));
        chk("rst_q", 384'(o_q_data), 384'(0));
        chk("rst_deq", 384'(o_deq_data), 384'(0));
        mon_on = 1'b1;

        // Basic pass: scale factor preloaded, cycle-exact latency and completion.
        next();
        load_sf(sf_all(1024));
        fill_pattern(1);
        i_start = 1'b1;
        next();
        i_start = 1'b0;
        #1;
        chk("c1_ram_re", 384'({o_ram_re, o_busy}), 384'(2'b11));
        chk("c1_ram_addr", 384'(o_ram_addr), 384'(0));
        next(); #1;
        chk("c2_valid", 384'(o_valid), 384'(0));
        next(); #1;
        chk("c3_valid_idx", 384'({o_valid, o_idx}), 384'({1'b1, 6'd0}));
        wait_done(200, cyc);
        chk("done_cycle", 384'(cyc + 3), 384'(DEPTH + 3));
        chk("done_busy_low", 384'(o_busy), 384'(0));

        // Rounding and saturation corners.
        next();
        fill_special();
        sp_bank = i_sf_data;
        load_sf(sp_bank);
        i_start = 1'b1;
        next();
        i_start = 1'b0;
        wait_done(200, cyc);

        // Backpressure with stalls.
        next();
        load_sf(sf_all(1024));
        fill_pattern(3);
        bp_mode = 1'b1;
        i_start = 1'b1;
        next();
        i_start = 1'b0;
        wait_done(2000, cyc);
        bp_mode = 1'b0;

        // Start without scale factors, then a mid-pass bank that must be ignored.
        next();
        fill_pattern(5);
        i_start = 1'b1;
        next();
        i_start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk("wait_sf_hold", 384'({o_busy, o_ram_re}), 384'(2'b10));
            next();
        end
        i_sf_valid = 1'b1;
        i_sf_data  = sf_all(1024);
        #1;
        chk("wait_sf_at_sf", 384'({o_busy, o_ram_re}), 384'(2'b10));
        next();
        i_sf_valid = 1'b0;
        #1;
        chk("first_re_after_sf", 384'({o_ram_re, o_ram_addr}), 384'({1'b1, 6'd0}));
        next();
        next();
        load_sf(sf_all(2048));
        wait_done(200, cyc);

        // Reset in the middle of a pass.
        next();
        load_sf(sf_all(1024));
        fill_pattern(7);
        i_start = 1'b1;
        next();
        i_start = 1'b0;
        cyc = 0;
        while (cyc < 200) begin
            next();
            #1;
            cyc++;
            if (o_valid && o_idx == 6'd20) break;
        end
        chk("reached_idx20", 384'({o_valid, o_idx}), 384'({1'b1, 6'd20}));
        i_rst = 1'b1;
        next();
        i_rst = 1'b0;
        #1;
        chk("rst_mid_outputs", 384'({o_valid, o_busy, o_done}), 384'(3'b000));
        sb.delete();
        for (int c = 0; c < 5; c++) begin
            next();
            #1;
            chk("rst_mid_no_done", 384'({o_done, o_busy}), 384'(2'b00));
        end
        load_sf(sf_all(1024));
        fill_pattern(2);
        i_start = 1'b1;
        next();
        i_start = 1'b0;
        #1;
        chk("restart_addr0", 384'({o_ram_re, o_ram_addr}), 384'({1'b1, 6'd0}));
        wait_done(200, cyc);

        // Back-to-back: start held across o_done goes through WAIT_SF.
        next();
        load_sf(sf_all(1024));
        fill_pattern(4);
        i_start = 1'b1;
        next();
        wait_done(200, cyc);
        next();
        i_start = 1'b0;
        #1;
        chk("b2b_wait_sf", 384'({o_busy, o_ram_re}), 384'(2'b10));
        for (int c = 0; c < 3; c++) begin
            next();
            #1;
            chk("b2b_stall", 384'({o_busy, o_ram_re}), 384'(2'b10));
        end
        fill_pattern(6);
        load_sf(sf_all(1024));
        #1;
        chk("b2b_first_re", 384'({o_ram_re, o_ram_addr}), 384'({1'b1, 6'd0}));
        wait_done(200, cyc);

        // Second start with no fresh bank stalls until reset.
        next();
        i_start = 1'b1;
        next();
        i_start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("nosf_stall", 384'({o_busy, o_ram_re}), 384'(2'b10));
            next();
        end
        i_rst = 1'b1;
        next();
        i_rst = 1'b0;
        #1;
        chk("final_rst_busy", 384'(o_busy), 384'(0));
        next();
        chk("scoreboard_empty", 384'(sb.size()), 384'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
